// File: rtl/seq_pkg.sv
// seq_pkg: shared states and program-base defaults for the run-control sequencer
package seq_pkg;
  localparam int DEF_PC_W = 10;
  localparam int DEF_OFF_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_PC_W-1:0] BASE0 = 10'h000;
  localparam logic [DEF_PC_W-1:0] BASE1 = 10'h100;
  localparam logic [DEF_PC_W-1:0] BASE2 = 10'h200;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
endpackage

// File: rtl/pc_next.sv
// pc_next: sequential or branch-target program counter (pc+1 or pc+1+sext(offset))
module pc_next #(
  parameter int PC_W = 10,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             take_branch,
  output logic [PC_W-1:0]  nxt
);
  logic [PC_W-1:0] sext;
  always_comb begin
    sext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    nxt = pc + PC_W'(1) + (take_branch ? sext : '0);
  end
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: start/done handshake, PC sequencing, commit gating and cycle count
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [PC_W-1:0] PROG0_BASE = PC_W'(BASE0),
  parameter logic [PC_W-1:0] PROG1_BASE = PC_W'(BASE1),
  parameter logic [PC_W-1:0] PROG2_BASE = PC_W'(BASE2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       prog_sel,
  input  logic             done_instr,
  input  logic             take_branch,
  input  logic [OFF_W-1:0] offset,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic             run,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count
);
  state_t state, state_n;
  logic start, reject, adv;
  logic [PC_W-1:0] pc_nx, base;
  pc_next #(.PC_W(PC_W), .OFF_W(OFF_W)) u_pc_next (
    .pc(pc),
    .offset(offset),
    .take_branch(take_branch),
    .nxt(pc_nx)
  );
  always_comb begin
    start = state == IDLE && req && prog_sel != 2'd3;
    reject = state == IDLE && req && prog_sel == 2'd3;
    adv = run && !done_instr;
    base = prog_sel == 2'd0 ? PROG0_BASE : prog_sel == 2'd1 ? PROG1_BASE : PROG2_BASE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = RUN;
      RUN:  state_n = (!stall && done_instr) ? HALT : RUN;
      HALT: state_n = req ? HALT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb run = state == RUN && !stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      done <= 1'b0;
      err <= 1'b0;
      cycle_count <= '0;
    end else begin
      done <= state_n == HALT;
      err <= reject;
      if (start) pc <= base;
      else if (adv) pc <= pc_nx;
      if (start) cycle_count <= '0;
      else if (run && !(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: vector table plus hand-written sequences, scoreboard-checked
module tb_prog_sequencer;
  logic clk = 1'b0;
  logic reset, req, done_instr, take_branch, stall;
  logic [1:0] prog_sel;
  logic [7:0] offset;
  logic [9:0] pc, pc_s;
  logic run, done, err, run_s, done_s, err_s;
  logic [15:0] cycle_count;
  logic [2:0] cnt_s;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic r; logic [1:0] s; logic d, b; logic [7:0] o; logic st;
    logic [9:0] pc; logic run, done, err; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  prog_sequencer u_dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .done_instr(done_instr),
    .take_branch(take_branch), .offset(offset), .stall(stall), .pc(pc), .run(run),
    .done(done), .err(err), .cycle_count(cycle_count)
  );
  prog_sequencer #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .done_instr(done_instr),
    .take_branch(take_branch), .offset(offset), .stall(stall), .pc(pc_s), .run(run_s),
    .done(done_s), .err(err_s), .cycle_count(cnt_s)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t v(input logic r, input logic [1:0] s, input logic d, input logic b,
                             input logic [7:0] o, input logic st, input logic [9:0] epc,
                             input logic erun, input logic edone, input logic eerr, input logic [15:0] ecnt);
    vec_t x;
    x.r = r; x.s = s; x.d = d; x.b = b; x.o = o; x.st = st;
    x.pc = epc; x.run = erun; x.done = edone; x.err = eerr; x.cnt = ecnt;
    return x;
  endfunction
  task automatic drive(input logic r, input logic [1:0] s, input logic d, input logic b,
                       input logic [7:0] o, input logic st);
    req = r; prog_sel = s; done_instr = d; take_branch = b; offset = o; stall = st;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input vec_t x, input int idx);
    vec_t e;
    drive(x.r, x.s, x.d, x.b, x.o, x.st);
    sb.push_back(x);
    tick();
    e = sb.pop_front();
    chk($sformatf("v%0d pc", idx), 32'(pc), 32'(e.pc));
    chk($sformatf("v%0d run", idx), 32'(run), 32'(e.run));
    chk($sformatf("v%0d done", idx), 32'(done), 32'(e.done));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(e.err));
    chk($sformatf("v%0d cnt", idx), 32'(cycle_count), 32'(e.cnt));
  endtask
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    tick();
    chk("rst pc", 32'(pc), 0);
    chk("rst run", 32'(run), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst cnt", 32'(cycle_count), 0);
    reset = 1'b0;
    //          r  s  d  b  off    st  pc      run done err cnt
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 10'h000, 0, 0, 0, 0));
    tbl.push_back(v(1, 3, 0, 0, 8'h00, 0, 10'h000, 0, 0, 1, 0));
    tbl.push_back(v(1, 3, 0, 0, 8'h00, 0, 10'h000, 0, 0, 1, 0));
    tbl.push_back(v(0, 3, 0, 0, 8'h00, 0, 10'h000, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 8'h00, 0, 10'h100, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 10'h100, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 10'h101, 1, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 10'h102, 1, 0, 0, 2));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 1, 10'h102, 0, 0, 0, 2));
    tbl.push_back(v(0, 1, 1, 1, 8'h05, 1, 10'h102, 0, 0, 0, 2));
    tbl.push_back(v(0, 1, 0, 1, 8'hFD, 0, 10'h100, 1, 0, 0, 3));
    tbl.push_back(v(0, 1, 1, 1, 8'h05, 0, 10'h100, 0, 1, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 10'h100, 0, 1, 0, 4));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 10'h100, 0, 0, 0, 4));
    tbl.push_back(v(1, 2, 0, 0, 8'h00, 0, 10'h200, 0, 0, 0, 0));
    tbl.push_back(v(0, 2, 0, 0, 8'h00, 0, 10'h200, 1, 0, 0, 0));
    tbl.push_back(v(0, 2, 0, 1, 8'h05, 0, 10'h206, 1, 0, 0, 1));
    tbl.push_back(v(0, 2, 0, 1, 8'h7F, 0, 10'h286, 1, 0, 0, 2));
    tbl.push_back(v(0, 2, 0, 1, 8'h80, 0, 10'h207, 1, 0, 0, 3));
    tbl.push_back(v(0, 2, 1, 0, 8'h00, 0, 10'h207, 0, 1, 0, 4));
    tbl.push_back(v(0, 2, 0, 0, 8'h00, 0, 10'h207, 0, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 10'h000, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 10'h000, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 8'hFD, 0, 10'h3FE, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 10'h3FF, 1, 0, 0, 2));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 10'h000, 1, 0, 0, 3));
    tbl.push_back(v(0, 0, 0, 1, 8'h0F, 0, 10'h010, 1, 0, 0, 4));
    tbl.push_back(v(0, 0, 0, 1, 8'hFD, 0, 10'h00E, 1, 0, 0, 5));
    tbl.push_back(v(0, 0, 0, 1, 8'h20, 1, 10'h00E, 0, 0, 0, 5));
    tbl.push_back(v(0, 0, 1, 1, 8'h20, 0, 10'h00E, 0, 1, 0, 6));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 1, 10'h00E, 0, 0, 0, 6));
    tbl.push_back(v(0, 0, 1, 1, 8'h04, 0, 10'h00E, 0, 0, 0, 6));
    foreach (tbl[i]) step(tbl[i], i);
    // reset in the middle of program 1 at pc=0x105
    drive(1, 1, 0, 0, 8'h00, 0);
    tick();
    drive(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("mid pc", 32'(pc), 32'h105);
    chk("mid cnt", 32'(cycle_count), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst pc", 32'(pc), 0);
    chk("mrst run", 32'(run), 0);
    chk("mrst done", 32'(done), 0);
    chk("mrst cnt", 32'(cycle_count), 0);
    tick();
    chk("mrst idle pc", 32'(pc), 0);
    // 10-cycle program: narrow counter saturates at 7 instead of wrapping
    drive(1, 0, 0, 0, 8'h00, 0);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    for (int i = 0; i < 9; i++) tick();
    drive(0, 0, 1, 0, 8'h00, 0);
    tick();
    chk("sat cnt16", 32'(cycle_count), 10);
    chk("sat cnt3", 32'(cnt_s), 7);
    chk("sat done", 32'(done_s), 1);
    chk("sat pc", 32'(pc), 32'h009);
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    chk("sat done drop", 32'(done), 0);
    chk("sat cnt3 held", 32'(cnt_s), 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
